// File: rtl/skp_os_generator.sv
// SKP Ordered Set generator: emits one Gen1/2 COM+3xSKP beat or a Gen3 SKP block
// on a 4-symbol TX path, then handshakes completion back to the SKP interval counter.
module skp_os_generator #(
   parameter int GEN3_SKP_SYMS = 12
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        gen,
   input  logic        skp_enable,
   input  logic        back_pressure,
   input  logic        skp_rst,
   input  logic [23:0] lfsr_status,
   input  logic        os_ready,
   output logic        os_valid,
   output logic [31:0] os_data,
   output logic [3:0]  os_k,
   output logic [1:0]  os_sync_hdr,
   output logic        os_blk_start,
   output logic        skp_busy,
   output logic        skp_done
);

   localparam int         G3_BEATS = (GEN3_SKP_SYMS + 4) / 4;
   localparam logic [2:0] G3_LAST  = 3'(G3_BEATS - 1);

   typedef enum logic [1:0] {IDLE, SEND, DONE, RELEASE} state_t;

   state_t      state, state_next;
   logic [2:0]  beat, beat_next;
   logic        gen_q, gen_next;
   logic [23:0] lfsr_q, lfsr_next;
   logic        last_beat;

   assign last_beat = gen_q ? (beat == G3_LAST) : (beat == 3'd0);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state  <= IDLE;
         beat   <= 3'd0;
         gen_q  <= 1'b0;
         lfsr_q <= 24'd0;
      end else begin
         state  <= state_next;
         beat   <= beat_next;
         gen_q  <= gen_next;
         lfsr_q <= lfsr_next;
      end
   end

   always_comb begin
      state_next = state;
      beat_next  = beat;
      gen_next   = gen_q;
      lfsr_next  = lfsr_q;
      unique case (state)
         IDLE: begin
            if (skp_enable) begin
               state_next = SEND;
               beat_next  = 3'd0;
               gen_next   = gen;
               lfsr_next  = lfsr_status;
            end
         end
         SEND: begin
            if (os_ready) begin
               if (last_beat) begin
                  state_next = DONE;
                  beat_next  = 3'd0;
               end else begin
                  beat_next = beat + 3'd1;
               end
            end
         end
         DONE: begin
            if (!back_pressure) state_next = RELEASE;
         end
         RELEASE: begin
            // The counter drops skp_enable a cycle after seeing done; wait it out.
            if (!skp_enable) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
      if (skp_rst) begin
         state_next = IDLE;
         beat_next  = 3'd0;
      end
   end

   always_comb begin
      os_valid     = (state == SEND);
      skp_busy     = (state == SEND);
      skp_done     = (state == DONE);
      os_blk_start = (state == SEND) && (beat == 3'd0);
      os_sync_hdr  = 2'b00;
      os_k         = 4'h0;
      os_data      = 32'd0;
      if (state == SEND) begin
         if (gen_q) begin
            // Symbol count is a multiple of 4, so SKP_END always opens the final beat.
            os_data     = last_beat ? {lfsr_q, 8'hE1} : 32'hAAAAAAAA;
            os_sync_hdr = (beat == 3'd0) ? 2'b01 : 2'b00;
         end else begin
            os_data = 32'h1C1C1CBC;
            os_k    = 4'hF;
         end
      end
   end

endmodule

// File: tb/tb_skp_os_generator.sv
// Randomized bench for skp_os_generator: three instances (4, 12 and 20 SKP symbols)
// share stimulus and are checked against a byte-stream reference model.
module tb_skp_os_generator;

   localparam int SYMS [3] = '{4, 12, 20};

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        gen = 1'b0;
   logic        skp_enable = 1'b0;
   logic        back_pressure = 1'b0;
   logic        skp_rst = 1'b0;
   logic [23:0] lfsr_status = 24'd0;
   logic        os_ready = 1'b0;

   logic        os_valid [3];
   logic [31:0] os_data [3];
   logic [3:0]  os_k [3];
   logic [1:0]  os_sync_hdr [3];
   logic        os_blk_start [3];
   logic        skp_busy [3];
   logic        skp_done [3];

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   for (genvar g = 0; g < 3; g++) begin : g_dut
      skp_os_generator #(.GEN3_SKP_SYMS(SYMS[g])) dut (
         .clk(clk), .rst(rst), .gen(gen), .skp_enable(skp_enable),
         .back_pressure(back_pressure), .skp_rst(skp_rst), .lfsr_status(lfsr_status),
         .os_ready(os_ready), .os_valid(os_valid[g]), .os_data(os_data[g]), .os_k(os_k[g]),
         .os_sync_hdr(os_sync_hdr[g]), .os_blk_start(os_blk_start[g]),
         .skp_busy(skp_busy[g]), .skp_done(skp_done[g])
      );
   end

   // Reference: lay the whole ordered set out as a byte stream, then cut out one beat.
   function automatic logic [31:0] model_word(int syms, logic g3, logic [23:0] lf, int b);
      logic [7:0] bytes [24];
      if (!g3) return 32'h1C1C1CBC;
      for (int i = 0; i < syms; i++) bytes[i] = 8'hAA;
      bytes[syms]   = 8'hE1;
      bytes[syms+1] = lf[7:0];
      bytes[syms+2] = lf[15:8];
      bytes[syms+3] = lf[23:16];
      return {bytes[4*b+3], bytes[4*b+2], bytes[4*b+1], bytes[4*b]};
   endfunction

   // Drives one complete ordered set through all instances and checks every cycle.
   task automatic run_os(input logic g3, input logic [23:0] lf, input int stall_pct,
                         input int stall_beat, input int bp_cycles, input bit rand_bp,
                         input int want_valid_cycles, input int want_done_cycles);
      int  acc [3];
      int  nb [3];
      bit  rel [3];
      bit  all_rel = 0;
      int  stall_left = 3;
      int  bp_left = bp_cycles;
      int  valid_cycles = 0;
      int  done_cycles = 0;
      for (int d = 0; d < 3; d++) begin
         acc[d] = 0;
         rel[d] = 0;
         nb[d]  = g3 ? (SYMS[d] + 4) / 4 : 1;
      end
      gen = g3;
      lfsr_status = lf;
      skp_enable = 1'b1;
      @(posedge clk); #1;
      for (int cyc = 0; cyc < 300 && !all_rel; cyc++) begin
         if (stall_beat >= 0 && acc[1] == stall_beat && stall_left > 0) begin
            os_ready = 1'b0;
            stall_left--;
         end else if (stall_beat >= 0) os_ready = 1'b1;
         else os_ready = ($urandom_range(0, 99) >= stall_pct);
         if (acc[1] == nb[1] && !rel[1] && bp_left > 0) begin
            back_pressure = 1'b1;
            bp_left--;
         end else back_pressure = rand_bp ? ($urandom_range(0, 2) == 0) : 1'b0;
         gen = 1'($urandom);
         lfsr_status = 24'($urandom);
         for (int d = 0; d < 3; d++) begin
            logic exp_valid, exp_done;
            logic [38:0] exp_beat, got_beat;
            exp_valid = (acc[d] < nb[d]);
            exp_done  = (acc[d] == nb[d]) && !rel[d];
            checks++;
            if (os_valid[d] !== exp_valid || skp_busy[d] !== exp_valid || skp_done[d] !== exp_done) begin
               errors++;
               $display("[TB] FAIL handshake dut%0d cyc%0d: valid/busy/done got %b%b%b want %b%b%b",
                        d, cyc, os_valid[d], skp_busy[d], skp_done[d], exp_valid, exp_valid, exp_done);
            end
            if (exp_valid) begin
               exp_beat = {model_word(SYMS[d], g3, lf, acc[d]), g3 ? 4'h0 : 4'hF,
                           (g3 && acc[d] == 0) ? 2'b01 : 2'b00, acc[d] == 0};
               got_beat = {os_data[d], os_k[d], os_sync_hdr[d], os_blk_start[d]};
               checks++;
               if (got_beat !== exp_beat) begin
                  errors++;
                  $display("[TB] FAIL beat dut%0d beat%0d: data/k/sync/blk got %h want %h",
                           d, acc[d], got_beat, exp_beat);
               end
            end
            if (d == 1 && exp_valid) valid_cycles++;
            if (d == 1 && exp_done) done_cycles++;
            if (exp_valid && os_ready) acc[d]++;
            else if (exp_done && !back_pressure) rel[d] = 1;
         end
         all_rel = rel[0] && rel[1] && rel[2];
         @(posedge clk); #1;
      end
      if (!all_rel) begin
         checks++;
         errors++;
         $display("[TB] FAIL timeout: ordered set never released, got %b%b%b want 111", rel[0], rel[1], rel[2]);
      end
      back_pressure = 1'b0;
      if (want_valid_cycles >= 0) begin
         checks++;
         if (valid_cycles != want_valid_cycles) begin
            errors++;
            $display("[TB] FAIL valid_cycles: got %0d want %0d", valid_cycles, want_valid_cycles);
         end
      end
      if (want_done_cycles >= 0) begin
         checks++;
         if (done_cycles != want_done_cycles) begin
            errors++;
            $display("[TB] FAIL done_cycles: got %0d want %0d", done_cycles, want_done_cycles);
         end
      end
      // Stale skp_enable must not retrigger.
      for (int i = 0; i < 4; i++) begin
         if (i == 3) skp_enable = 1'b0;
         for (int d = 0; d < 3; d++) begin
            checks++;
            if (os_valid[d] !== 1'b0 || skp_done[d] !== 1'b0) begin
               errors++;
               $display("[TB] FAIL retrigger dut%0d: valid/done got %b%b want 00", d, os_valid[d], skp_done[d]);
            end
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_reset();
      #2;
      for (int d = 0; d < 3; d++) begin
         checks++;
         if ({os_valid[d], os_data[d], os_k[d], os_sync_hdr[d], os_blk_start[d], skp_busy[d], skp_done[d]} !== 42'd0) begin
            errors++;
            $display("[TB] FAIL reset dut%0d: outputs got nonzero want 0 (data %h)", d, os_data[d]);
         end
      end
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_gen1();
      run_os(1'b0, 24'($urandom), 0, -1, 0, 0, 1, 1);
      for (int i = 0; i < 3; i++) run_os(1'b0, 24'($urandom), 40, -1, 0, 1, -1, -1);
   endtask

   task automatic test_gen3();
      run_os(1'b1, 24'h563412, 0, -1, 0, 0, 4, 1);
      for (int i = 0; i < 6; i++) run_os(1'b1, 24'($urandom), 35, -1, 0, 1, -1, -1);
   endtask

   task automatic test_stall();
      run_os(1'b1, 24'($urandom), 0, 2, 0, 0, 7, 1);
   endtask

   task automatic test_back_pressure();
      run_os(1'b1, 24'($urandom), 0, -1, 5, 0, 4, 6);
      run_os(1'b0, 24'($urandom), 0, -1, 5, 0, 1, 6);
   endtask

   task automatic test_skp_rst();
      gen = 1'b1;
      lfsr_status = 24'($urandom);
      os_ready = 1'b1;
      skp_enable = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      checks++;
      if (os_valid[1] !== 1'b1 || os_blk_start[1] !== 1'b0) begin
         errors++;
         $display("[TB] FAIL skp_rst_setup: valid/blk got %b%b want 10", os_valid[1], os_blk_start[1]);
      end
      skp_rst = 1'b1;
      skp_enable = 1'b0;
      @(posedge clk); #1;
      for (int d = 0; d < 3; d++) begin
         checks++;
         if (os_valid[d] !== 1'b0 || skp_done[d] !== 1'b0) begin
            errors++;
            $display("[TB] FAIL skp_rst_abort dut%0d: valid/done got %b%b want 00", d, os_valid[d], skp_done[d]);
         end
      end
      skp_enable = 1'b1;
      @(posedge clk); #1;
      for (int d = 0; d < 3; d++) begin
         checks++;
         if (os_valid[d] !== 1'b0) begin
            errors++;
            $display("[TB] FAIL skp_rst_wins dut%0d: valid got %b want 0", d, os_valid[d]);
         end
      end
      skp_rst = 1'b0;
      skp_enable = 1'b0;
      @(posedge clk); #1;
      run_os(1'b1, 24'($urandom), 20, -1, 0, 1, -1, -1);
   endtask

   task automatic test_async_reset();
      gen = 1'b1;
      os_ready = 1'b0;
      skp_enable = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      #1;
      for (int d = 0; d < 3; d++) begin
         checks++;
         if (os_valid[d] !== 1'b0 || os_data[d] !== 32'd0 || skp_busy[d] !== 1'b0) begin
            errors++;
            $display("[TB] FAIL async_reset dut%0d: valid/busy got %b%b data %h want 00 0", d,
                     os_valid[d], skp_busy[d], os_data[d]);
         end
      end
      skp_enable = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      run_os(1'b0, 24'd0, 0, -1, 0, 0, 1, 1);
   endtask

   initial begin
      test_reset();
      test_gen1();
      test_gen3();
      test_stall();
      test_back_pressure();
      test_skp_rst();
      test_async_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
